decoder_scan_arbiter: RTL and testbench

Round-robin arbiter that shares one 7-way decoded select resource among seven requesters. A registered FSM chooses a 3-bit grant index, which drives an internal decoder_3to7 to produce the one-hot grant vector. The block replaces the free-running 3-bit counter as the source of the decoder's `in` code. Index 0 means "no grant"; indices 1..7 select requesters 0..6.

---
 rtl/decoder_scan_pkg.sv | 31 +++
 rtl/decoder_3to7.sv | 11 +
 rtl/decoder_scan_arbiter.sv | 101 ++++++++++
 tb/tb_decoder_scan_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types, constants and round-robin search for decoder_scan_arbiter.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int         NUM_REQ  = 7;
  localparam logic [2:0] IDX_IDLE = 3'd0;

  // First requesting index after ptr, wrapping 7 -> 1; ptr itself is tried last.
  // Returns IDX_IDLE when nothing is requesting.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                         input logic [NUM_REQ-1:0] req);
    logic [2:0] idx;
    logic       found;
    rr_next = IDX_IDLE;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == 3'd7) ? 3'd1 : idx + 3'd1;
      if (!found && req[idx - 3'd1]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_3to7.sv
// 3-to-7 decoder: code k (1..7) raises out[k-1]; code 0 gives all zeros.
module decoder_3to7 (
  input  logic [2:0] in,
  output logic [6:0] out
);

  for (genvar k = 1; k <= 7; k++) begin : g_dec
    assign out[k-1] = (in == 3'(k));
  end

endmodule

// File: rtl/decoder_scan_arbiter.sv
// Round-robin arbiter over seven requesters driving a 3-to-7 decoded grant.
// Optional forced release after HOLD_MAX cycles: DECODER_SCAN_HOLD_TIMEOUT_EN.
module decoder_scan_arbiter
  import decoder_scan_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [2:0]         grant_idx,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] grant
);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt, idx_nxt, win;
  logic       rel, tmo;

  assign win = rr_next(ptr, req);

`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
  logic [3:0] hold_cnt, hold_nxt;
  // hold_cnt is 0 in the first grant cycle, so this fires in cycle HOLD_MAX
  assign tmo = (hold_cnt == 4'(HOLD_MAX - 1));
`else
  // no forced release; HOLD_MAX has no effect in this build
  logic unused_hold;
  assign unused_hold = ^HOLD_MAX;
  assign tmo         = 1'b0;
`endif

  // any exit condition releases once; grant_idx is nonzero whenever in GRANT
  assign rel = done || !req[grant_idx - 3'd1] || tmo;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      grant_idx   <= IDX_IDLE;
      grant_valid <= 1'b0;
      ptr         <= 3'd7;
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
      hold_cnt    <= 4'd0;
`endif
    end else begin
      state       <= state_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= (idx_nxt != IDX_IDLE);
      ptr         <= ptr_nxt;
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
      hold_cnt    <= hold_nxt;
`endif
    end
  end

  // next-state: IDLE -> GRANT on any request, GRANT -> GAP on release, GAP -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (rel)  state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next grant code, pointer and hold counter
  always_comb begin
    idx_nxt  = grant_idx;
    ptr_nxt  = ptr;
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
    hold_nxt = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nxt  = win;
          ptr_nxt  = win;
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
          hold_nxt = 4'd0;
`endif
        end
      end
      GRANT: begin
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
        if (hold_cnt != 4'd15) hold_nxt = hold_cnt + 4'd1;
`endif
        if (rel) idx_nxt = IDX_IDLE;
      end
      default: idx_nxt = IDX_IDLE;
    endcase
  end

  decoder_3to7 u_dec (
    .in  (grant_idx),
    .out (grant)
  );

endmodule

// File: tb/tb_decoder_scan_arbiter.sv
// Self-checking bench for decoder_scan_arbiter: directed scenarios plus random
// traffic, each cycle compared against a transaction-level reference model.
// Build with DECODER_SCAN_HOLD_TIMEOUT_EN to exercise the forced release.
module tb_decoder_scan_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [6:0] grant;

  int n_chk = 0;
  int n_err = 0;

  // reference model: who holds the resource, whether a break cycle is pending,
  // who was served last, and how many grant cycles the holder has used
  int m_cur  = 0;
  bit m_gap  = 0;
  int m_last = 7;
  int m_held = 0;

  decoder_scan_arbiter #(.HOLD_MAX(HM)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [6:0] q, input logic d);
    bit leave;
    if (!r) begin
      m_cur = 0; m_gap = 0; m_last = 7; m_held = 0;
    end else if (m_cur != 0) begin
      m_held++;
      leave = d || !q[m_cur-1];
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
      if (m_held >= HM) leave = 1;
`endif
      if (leave) begin m_cur = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (q != 0) begin
      for (int k = 1; k <= 7; k++) begin
        int c;
        c = (m_last + k - 1) % 7 + 1;
        if (q[c-1]) begin m_cur = c; m_last = c; m_held = 0; break; end
      end
    end
  endtask

  // drive inputs, clock once, update the model and compare all outputs
  task automatic cyc(input logic r, input logic [6:0] q, input logic d);
    int eg;
    reset = r; req = q; done = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
    eg = (m_cur != 0) ? (1 << (m_cur - 1)) : 0;
    chk("grant_idx", int'(grant_idx), m_cur);
    chk("grant_valid", int'(grant_valid), int'(m_cur != 0));
    chk("grant", int'(grant), eg);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 7'h7F, 1'b0);
  endtask

  initial begin
    int seq[$];
    int exp_rr[8];
    int exp_sp[4];
    int run, maxrun, zeros, lim;
    bit prev;
    logic [6:0] q;
    logic d, r;

    reset = 1'b0; req = '0; done = 1'b0;
    @(negedge clk);

    // reset held with every requester active
    do_reset(8);
    cyc(1'b1, 7'h7F, 1'b0);
    chk("first_idx", int'(grant_idx), 1);
    chk("first_grant", int'(grant), 7'h01);

    // full round-robin with done raised during each grant
    do_reset(2);
    seq = {}; prev = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 7'h7F, m_cur != 0);
      if (grant_valid && !prev) seq.push_back(int'(grant_idx));
      prev = grant_valid;
    end
    exp_rr = '{1, 2, 3, 4, 5, 6, 7, 1};
    chk("rr_count", int'(seq.size() >= 8), 1);
    for (int i = 0; i < 8 && i < seq.size(); i++) chk("rr_seq", seq[i], exp_rr[i]);

    // sparse requesters 2 and 6 alternate as codes 3 and 7
    do_reset(2);
    seq = {}; prev = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 7'b1000100, m_cur != 0);
      if (grant_valid && !prev) seq.push_back(int'(grant_idx));
      prev = grant_valid;
    end
    exp_sp = '{3, 7, 3, 7};
    chk("sp_count", int'(seq.size() >= 4), 1);
    for (int i = 0; i < 4 && i < seq.size(); i++) chk("sp_seq", seq[i], exp_sp[i]);

    // single requester never releasing on its own
    do_reset(2);
    run = 0; maxrun = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 7'h01, 1'b0);
      run = grant_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
`ifdef DECODER_SCAN_HOLD_TIMEOUT_EN
    chk("hold_run", maxrun, HM);
`else
    chk("hold_run", maxrun, 20);
`endif

    // done, req drop and (if built) timeout all in the same cycle
    do_reset(2);
    cyc(1'b1, 7'h01, 1'b0);
    for (int i = 0; i < HM - 1; i++) cyc(1'b1, 7'h01, 1'b0);
    cyc(1'b1, 7'h00, 1'b1);
    chk("sim_rel", int'(grant_valid), 0);
    zeros = 1; lim = 0;
    while (lim < 10) begin
      cyc(1'b1, 7'h01, 1'b0);
      lim++;
      if (grant_valid) break;
      zeros++;
    end
    chk("sim_gap", zeros, 2);
    chk("sim_timeout", int'(lim < 10), 1);

    // reset while code 5 is granted returns the pointer to 7
    do_reset(2);
    cyc(1'b1, 7'h10, 1'b0);
    chk("mid_idx5", int'(grant_idx), 5);
    cyc(1'b0, 7'h10, 1'b0);
    chk("mid_drop", int'(grant_idx), 0);
    cyc(1'b1, 7'h7F, 1'b0);
    chk("mid_restart", int'(grant_idx), 1);

    // random traffic, including done pulses with no grant and rare resets
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      q = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      if ($urandom_range(0, 1) == 0) q = req;
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 49) != 0);
      cyc(r, q, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
